// File: rtl/alu_div_seq_if.sv
// Handshake and operand bus between the EX stage and the sequential divider.
interface alu_div_seq_if #(parameter int WIDTH = 32);
  logic             enable_i;
  logic [1:0]       operator_i;
  logic [WIDTH-1:0] operand_a_i;
  logic [WIDTH-1:0] operand_b_i;
  logic             ex_ready_i;
  logic [WIDTH-1:0] result_o;
  logic             ready_o;
  logic             busy_o;

  modport master (
    output enable_i, operator_i, operand_a_i, operand_b_i, ex_ready_i,
    input  result_o, ready_o, busy_o
  );

  modport slave (
    input  enable_i, operator_i, operand_a_i, operand_b_i, ex_ready_i,
    output result_o, ready_o, busy_o
  );
endinterface

// File: rtl/alu_div_seq.sv
// Sequential restoring divider (DIVU/DIV/REMU/REM): one quotient bit per cycle,
// with zero-divisor and small-dividend shortcuts straight to DONE.
module alu_div_seq #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_TERM = 1'b1
) (
  input logic          core_clk,
  input logic          rst_n,
  alu_div_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] quo_q, rem_q, div_q, res_q, cnt_q;
  logic             rem_sel_q, neg_quo_q, neg_rem_q;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic             zero_div, early_hit;
  logic [WIDTH:0]   step_rs;
  logic [WIDTH+1:0] step_diff;
  logic             step_ok;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    return cond_neg(x, sgn & x[WIDTH-1]);
  endfunction

  assign abs_a     = mag(bus.operand_a_i, bus.operator_i[0]);
  assign abs_b     = mag(bus.operand_b_i, bus.operator_i[0]);
  assign zero_div  = (bus.operand_b_i == '0);
  assign early_hit = EARLY_TERM && !zero_div && (abs_a < abs_b);

  // Restoring step: shift next dividend bit into the partial remainder, trial-subtract.
  assign step_rs   = {rem_q, quo_q[WIDTH-1]};
  assign step_diff = {1'b0, step_rs} - {2'b00, div_q};
  assign step_ok   = ~step_diff[WIDTH+1];

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.enable_i) state_d = (zero_div || early_hit) ? DONE : CALC;
      CALC: if (cnt_q == CNT_LAST) state_d = DONE;
      DONE: if (bus.ex_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q     <= '0;
      rem_q     <= '0;
      div_q     <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      rem_sel_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.enable_i) begin
          quo_q     <= abs_a;
          rem_q     <= '0;
          div_q     <= abs_b;
          cnt_q     <= '0;
          rem_sel_q <= bus.operator_i[1];
          neg_quo_q <= bus.operator_i[0] & (bus.operand_a_i[WIDTH-1] ^ bus.operand_b_i[WIDTH-1]);
          neg_rem_q <= bus.operator_i[0] & bus.operand_a_i[WIDTH-1];
          if (zero_div)
            res_q <= bus.operator_i[1] ? bus.operand_a_i : '1;
          else if (early_hit)
            res_q <= bus.operator_i[1] ? bus.operand_a_i : '0;
        end
        CALC: begin
          if (cnt_q != CNT_LAST) begin
            quo_q <= {quo_q[WIDTH-2:0], step_ok};
            rem_q <= step_ok ? step_diff[WIDTH-1:0] : step_rs[WIDTH-1:0];
            cnt_q <= cnt_q + CNT_ONE;
          end else begin
            // Sign fix-up happens on the extra cycle so the result register loads once.
            res_q <= rem_sel_q ? cond_neg(rem_q, neg_rem_q) : cond_neg(quo_q, neg_quo_q);
          end
        end
        DONE: if (bus.ex_ready_i) res_q <= '0;
        default: res_q <= '0;
      endcase
    end
  end

  assign bus.result_o = res_q;
  assign bus.ready_o  = (state_q == DONE);
  assign bus.busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_alu_div_seq.sv
// Randomized and directed bench for alu_div_seq (32-bit and 8-bit instances).
module tb_alu_div_seq;

  logic core_clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 core_clk = ~core_clk;

  alu_div_seq_if #(.WIDTH(32)) bus32 ();
  alu_div_seq_if #(.WIDTH(8))  bus8 ();

  alu_div_seq #(.WIDTH(32), .EARLY_TERM(1'b1)) dut32 (
    .core_clk(core_clk), .rst_n(rst_n), .bus(bus32)
  );
  alu_div_seq #(.WIDTH(8), .EARLY_TERM(1'b1)) dut8 (
    .core_clk(core_clk), .rst_n(rst_n), .bus(bus8)
  );

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic on 64-bit integers.
  task automatic ref32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    longint sa, sb, q, r, ma, mb;
    sa = op[0] ? longint'($signed(a)) : longint'({32'b0, a});
    sb = op[0] ? longint'($signed(b)) : longint'({32'b0, b});
    if (b == 0) begin
      q = -1;
      r = sa;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    res = op[1] ? r[31:0] : q[31:0];
    ma  = (sa < 0) ? -sa : sa;
    mb  = (sb < 0) ? -sb : sb;
    lat = (b == 0 || ma < mb) ? 1 : 33;
  endtask

  task automatic run32(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                       input int hold);
    int lat;
    @(negedge core_clk);
    bus32.operator_i  = op;
    bus32.operand_a_i = a;
    bus32.operand_b_i = b;
    bus32.enable_i    = 1'b1;
    @(posedge core_clk); #1;
    chk_eq({tag, "_busy"}, 64'(bus32.busy_o), 64'd1);
    @(negedge core_clk);
    bus32.enable_i    = 1'b0;
    bus32.operator_i  = 2'($urandom_range(0, 3));
    bus32.operand_a_i = $urandom;
    bus32.operand_b_i = $urandom;
    lat = 0;
    while (lat < 100) begin
      @(posedge core_clk); #1;
      lat++;
      if (bus32.ready_o) break;
    end
    chk_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk_eq({tag, "_res"}, 64'(bus32.result_o), 64'(exp_res));
    for (int h = 0; h < hold; h++) begin
      @(negedge core_clk);
      bus32.enable_i    = 1'($urandom_range(0, 1));
      bus32.operand_a_i = $urandom;
      bus32.operand_b_i = $urandom;
      @(posedge core_clk); #1;
      chk_eq({tag, "_hold_res"}, 64'(bus32.result_o), 64'(exp_res));
      chk_eq({tag, "_hold_rdy"}, 64'(bus32.ready_o), 64'd1);
    end
    @(negedge core_clk);
    bus32.enable_i   = 1'b0;
    bus32.ex_ready_i = 1'b1;
    @(posedge core_clk); #1;
    chk_eq({tag, "_rdy_drop"}, 64'(bus32.ready_o), 64'd0);
    chk_eq({tag, "_idle"}, 64'(bus32.busy_o), 64'd0);
    chk_eq({tag, "_res_clr"}, 64'(bus32.result_o), 64'd0);
    @(negedge core_clk);
    bus32.ex_ready_i = 1'b0;
  endtask

  task automatic run8(input string tag, input logic [1:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] exp_res, input int exp_lat);
    int lat;
    @(negedge core_clk);
    bus8.operator_i  = op;
    bus8.operand_a_i = a;
    bus8.operand_b_i = b;
    bus8.enable_i    = 1'b1;
    @(posedge core_clk); #1;
    @(negedge core_clk);
    bus8.enable_i = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge core_clk); #1;
      lat++;
      if (bus8.ready_o) break;
    end
    chk_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk_eq({tag, "_res"}, 64'(bus8.result_o), 64'(exp_res));
    @(negedge core_clk);
    bus8.ex_ready_i = 1'b1;
    @(posedge core_clk); #1;
    chk_eq({tag, "_idle"}, 64'(bus8.busy_o), 64'd0);
    @(negedge core_clk);
    bus8.ex_ready_i = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0, 1:    return $urandom;
      2:       return 32'($urandom_range(0, 20));
      3:       return 32'h0;
      4:       return 32'hFFFF_FFFF;
      5:       return 32'h8000_0000;
      default: return -32'($urandom_range(1, 20));
    endcase
  endfunction

  initial begin
    logic [31:0] ra, rb, rres;
    logic [1:0]  rop;
    int          rlat;
    bus32.enable_i = 1'b0; bus32.operator_i = 2'b00; bus32.ex_ready_i = 1'b0;
    bus32.operand_a_i = '0; bus32.operand_b_i = '0;
    bus8.enable_i = 1'b0; bus8.operator_i = 2'b00; bus8.ex_ready_i = 1'b0;
    bus8.operand_a_i = '0; bus8.operand_b_i = '0;
    rst_n = 1'b0;

    // Requests during reset must be ignored.
    repeat (2) @(posedge core_clk);
    @(negedge core_clk);
    bus32.enable_i = 1'b1; bus32.operand_a_i = 32'd100; bus32.operand_b_i = 32'd7;
    @(posedge core_clk); #1;
    chk_eq("rst_busy", 64'(bus32.busy_o), 64'd0);
    chk_eq("rst_ready", 64'(bus32.ready_o), 64'd0);
    chk_eq("rst_result", 64'(bus32.result_o), 64'd0);
    @(negedge core_clk);
    bus32.enable_i = 1'b0;
    rst_n = 1'b1;

    run32("divu_100_7", 2'b00, 32'd100, 32'd7, 32'd14, 33, 0);
    run32("remu_100_7", 2'b10, 32'd100, 32'd7, 32'd2, 33, 0);
    run32("div_m7_2", 2'b01, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
    run32("rem_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
    run32("div_7_m2", 2'b01, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 0);
    run32("divu_5_0", 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run32("remu_5_0", 2'b10, 32'd5, 32'd0, 32'd5, 1, 0);
    run32("rem_m5_0", 2'b11, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1, 0);
    run32("div_ovf", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 0);
    run32("rem_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, 0);
    run32("early_rem", 2'b11, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFD, 1, 0);
    run32("hold_divu", 2'b00, 32'd100, 32'd7, 32'd14, 33, 5);

    // Abort in the 10th CALC cycle.
    @(negedge core_clk);
    bus32.operator_i = 2'b00; bus32.operand_a_i = 32'hFFFF_FFFF; bus32.operand_b_i = 32'd3;
    bus32.enable_i = 1'b1;
    @(posedge core_clk); #1;
    @(negedge core_clk);
    bus32.enable_i = 1'b0;
    repeat (9) @(posedge core_clk);
    @(negedge core_clk);
    rst_n = 1'b0;
    #1;
    chk_eq("abort_ready", 64'(bus32.ready_o), 64'd0);
    chk_eq("abort_busy", 64'(bus32.busy_o), 64'd0);
    chk_eq("abort_result", 64'(bus32.result_o), 64'd0);
    @(negedge core_clk);
    rst_n = 1'b1;
    run32("post_rst_9_3", 2'b00, 32'd9, 32'd3, 32'd3, 33, 0);

    run8("w8_divu_ff_10", 2'b00, 8'hFF, 8'h10, 8'h0F, 9);
    run8("w8_early", 2'b00, 8'd3, 8'd200, 8'd0, 1);
    run8("w8_div_ovf", 2'b01, 8'h80, 8'hFF, 8'h80, 9);
    run8("w8_rem_m7_2", 2'b11, 8'hF9, 8'd2, 8'hFF, 9);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = pick();
      rb  = pick();
      ref32(rop, ra, rb, rres, rlat);
      run32($sformatf("rnd%0d", i), rop, ra, rb, rres, rlat, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
